// File: rtl/dma_cmd_arbiter.sv
// dma_cmd_arbiter: weighted round-robin merge of the data_bridge write/read DMA
// command channels onto one host port, with per-channel outstanding limits.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   wr_cmd_* / rd_cmd_*         channel commands (valid/ready + data/be/ea/tag)
//   m_cmd_*                     merged registered command, tag = {is_rd, tag}
//   resp_*                      merged response in (tag MSB selects channel)
//   wr_resp_valid/rd_resp_valid routed response strobes, lcl_resp_* shared payload
//   outst_wr/outst_rd, idle     outstanding counts, idle flag
//   fir_underflow               sticky: final response seen with count at zero
module dma_cmd_arbiter #(
  parameter int TAGW      = 7,
  parameter int WR_WEIGHT = 4,
  parameter int RD_WEIGHT = 4,
  parameter int MAX_OUTST = 32,
  localparam int OUTW     = $clog2(MAX_OUTST + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_cmd_valid,
  output logic              wr_cmd_ready,
  input  logic [1023:0]     wr_cmd_data,
  input  logic [127:0]      wr_cmd_be,
  input  logic [63:0]       wr_cmd_ea,
  input  logic [TAGW-1:0]   wr_cmd_tag,
  input  logic              rd_cmd_valid,
  output logic              rd_cmd_ready,
  input  logic [1023:0]     rd_cmd_data,
  input  logic [127:0]      rd_cmd_be,
  input  logic [63:0]       rd_cmd_ea,
  input  logic [TAGW-1:0]   rd_cmd_tag,
  output logic              m_cmd_valid,
  input  logic              m_cmd_ready,
  output logic [1023:0]     m_cmd_data,
  output logic [127:0]      m_cmd_be,
  output logic [63:0]       m_cmd_ea,
  output logic [TAGW:0]     m_cmd_tag,
  output logic              m_cmd_rd,
  input  logic              resp_valid,
  input  logic [TAGW:0]     resp_tag,
  input  logic [1023:0]     resp_data,
  input  logic [1:0]        resp_pos,
  input  logic [2:0]        resp_code,
  output logic              wr_resp_valid,
  output logic              rd_resp_valid,
  output logic [TAGW-1:0]   lcl_resp_tag,
  output logic [1023:0]     lcl_resp_data,
  output logic [1:0]        lcl_resp_pos,
  output logic [2:0]        lcl_resp_code,
  output logic [OUTW-1:0]   outst_wr,
  output logic [OUTW-1:0]   outst_rd,
  output logic              idle,
  output logic              fir_underflow
);

  localparam int MAXW = (WR_WEIGHT > RD_WEIGHT) ? WR_WEIGHT : RD_WEIGHT;
  localparam int BW   = $clog2(MAXW + 1);
  localparam logic [OUTW-1:0] LIMIT = OUTW'(MAX_OUTST);
  localparam logic [BW-1:0]   WR_W  = BW'(WR_WEIGHT);
  localparam logic [BW-1:0]   RD_W  = BW'(RD_WEIGHT);

  typedef enum logic {
    OWN_WR = 1'b0,
    OWN_RD = 1'b1
  } owner_t;

  owner_t          owner, owner_nxt;
  logic [BW-1:0]   burst, burst_nxt;
  logic [BW-1:0]   own_w;
  logic            slot_free;
  logic            elig_wr, elig_rd;
  logic            own_elig, oth_elig;
  logic            gnt_wr, gnt_rd;
  logic            dec_wr, dec_rd;
  logic            uf_wr, uf_rd;
  logic [OUTW-1:0] outst_wr_nxt, outst_rd_nxt;

  always_comb begin
    slot_free = !m_cmd_valid || m_cmd_ready;
    elig_wr   = wr_cmd_valid && (outst_wr < LIMIT);
    elig_rd   = rd_cmd_valid && (outst_rd < LIMIT);
    own_elig  = (owner == OWN_RD) ? elig_rd : elig_wr;
    oth_elig  = (owner == OWN_RD) ? elig_wr : elig_rd;
    own_w     = (owner == OWN_RD) ? RD_W : WR_W;
    gnt_wr    = 1'b0;
    gnt_rd    = 1'b0;
    owner_nxt = owner;
    burst_nxt = burst;
    if (slot_free) begin
      if (own_elig && ((burst < own_w) || !oth_elig)) begin
        gnt_rd = (owner == OWN_RD);
        gnt_wr = (owner == OWN_WR);
        if (burst < own_w)
          burst_nxt = burst + 1'b1;
      end else if (oth_elig) begin
        // The switching grant is the first of the new owner's burst.
        owner_nxt = (owner == OWN_RD) ? OWN_WR : OWN_RD;
        gnt_rd    = (owner == OWN_WR);
        gnt_wr    = (owner == OWN_RD);
        burst_nxt = BW'(1);
      end
    end
  end

  assign wr_cmd_ready = gnt_wr;
  assign rd_cmd_ready = gnt_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner <= OWN_WR;
      burst <= '0;
    end else begin
      owner <= owner_nxt;
      burst <= burst_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cmd_valid <= 1'b0;
      m_cmd_data  <= '0;
      m_cmd_be    <= '0;
      m_cmd_ea    <= '0;
      m_cmd_tag   <= '0;
      m_cmd_rd    <= 1'b0;
    end else if (gnt_wr || gnt_rd) begin
      m_cmd_valid <= 1'b1;
      m_cmd_rd    <= gnt_rd;
      m_cmd_data  <= gnt_rd ? rd_cmd_data : wr_cmd_data;
      m_cmd_be    <= gnt_rd ? rd_cmd_be : wr_cmd_be;
      m_cmd_ea    <= gnt_rd ? rd_cmd_ea : wr_cmd_ea;
      m_cmd_tag   <= {gnt_rd, gnt_rd ? rd_cmd_tag : wr_cmd_tag};
    end else if (m_cmd_ready) begin
      m_cmd_valid <= 1'b0;
    end
  end

  always_comb begin
    dec_wr = resp_valid && resp_pos[1] && !resp_tag[TAGW];
    dec_rd = resp_valid && resp_pos[1] && resp_tag[TAGW];
    uf_wr  = dec_wr && !gnt_wr && (outst_wr == '0);
    uf_rd  = dec_rd && !gnt_rd && (outst_rd == '0);
    outst_wr_nxt = outst_wr;
    unique case (1'b1)
      (gnt_wr && !dec_wr):          outst_wr_nxt = outst_wr + 1'b1;
      (dec_wr && !gnt_wr && !uf_wr): outst_wr_nxt = outst_wr - 1'b1;
      default:                      outst_wr_nxt = outst_wr;
    endcase
    outst_rd_nxt = outst_rd;
    unique case (1'b1)
      (gnt_rd && !dec_rd):          outst_rd_nxt = outst_rd + 1'b1;
      (dec_rd && !gnt_rd && !uf_rd): outst_rd_nxt = outst_rd - 1'b1;
      default:                      outst_rd_nxt = outst_rd;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outst_wr      <= '0;
      outst_rd      <= '0;
      fir_underflow <= 1'b0;
    end else begin
      outst_wr <= outst_wr_nxt;
      outst_rd <= outst_rd_nxt;
      if (uf_wr || uf_rd)
        fir_underflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_resp_valid <= 1'b0;
      rd_resp_valid <= 1'b0;
      lcl_resp_tag  <= '0;
      lcl_resp_data <= '0;
      lcl_resp_pos  <= '0;
      lcl_resp_code <= '0;
    end else begin
      wr_resp_valid <= resp_valid && !resp_tag[TAGW];
      rd_resp_valid <= resp_valid && resp_tag[TAGW];
      if (resp_valid) begin
        lcl_resp_tag  <= resp_tag[TAGW-1:0];
        lcl_resp_data <= resp_data;
        lcl_resp_pos  <= resp_pos;
        lcl_resp_code <= resp_code;
      end
    end
  end

  assign idle = !m_cmd_valid && (outst_wr == '0) && (outst_rd == '0);

endmodule

// File: tb/tb_dma_cmd_arbiter.sv
// tb_dma_cmd_arbiter: directed vectors for dma_cmd_arbiter, MAX_OUTST=4.
// An optional auto-responder completes each issued command to keep counts low.
module tb_dma_cmd_arbiter;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_cmd_valid, wr_cmd_ready;
  logic [1023:0] wr_cmd_data;
  logic [127:0]  wr_cmd_be;
  logic [63:0]   wr_cmd_ea;
  logic [6:0]    wr_cmd_tag;
  logic          rd_cmd_valid, rd_cmd_ready;
  logic [1023:0] rd_cmd_data;
  logic [127:0]  rd_cmd_be;
  logic [63:0]   rd_cmd_ea;
  logic [6:0]    rd_cmd_tag;
  logic          m_cmd_valid, m_cmd_ready;
  logic [1023:0] m_cmd_data;
  logic [127:0]  m_cmd_be;
  logic [63:0]   m_cmd_ea;
  logic [7:0]    m_cmd_tag;
  logic          m_cmd_rd;
  logic          resp_valid;
  logic [7:0]    resp_tag;
  logic [1023:0] resp_data;
  logic [1:0]    resp_pos;
  logic [2:0]    resp_code;
  logic          wr_resp_valid, rd_resp_valid;
  logic [6:0]    lcl_resp_tag;
  logic [1023:0] lcl_resp_data;
  logic [1:0]    lcl_resp_pos;
  logic [2:0]    lcl_resp_code;
  logic [2:0]    outst_wr, outst_rd;
  logic          idle, fir_underflow;

  logic          auto_rsp;
  logic          man_valid;
  logic [7:0]    man_tag;
  logic [1:0]    man_pos;
  int            wr_n, rd_n;
  int            pass_cnt = 0;
  int            total_cnt = 0;

  always #5 clk = ~clk;

  assign resp_valid = auto_rsp ? m_cmd_valid : man_valid;
  assign resp_tag   = auto_rsp ? m_cmd_tag : man_tag;
  assign resp_pos   = auto_rsp ? 2'b11 : man_pos;

  dma_cmd_arbiter #(
    .TAGW(7), .WR_WEIGHT(4), .RD_WEIGHT(4), .MAX_OUTST(4)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready),
    .wr_cmd_data(wr_cmd_data), .wr_cmd_be(wr_cmd_be),
    .wr_cmd_ea(wr_cmd_ea), .wr_cmd_tag(wr_cmd_tag),
    .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready),
    .rd_cmd_data(rd_cmd_data), .rd_cmd_be(rd_cmd_be),
    .rd_cmd_ea(rd_cmd_ea), .rd_cmd_tag(rd_cmd_tag),
    .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready),
    .m_cmd_data(m_cmd_data), .m_cmd_be(m_cmd_be),
    .m_cmd_ea(m_cmd_ea), .m_cmd_tag(m_cmd_tag), .m_cmd_rd(m_cmd_rd),
    .resp_valid(resp_valid), .resp_tag(resp_tag),
    .resp_data(resp_data), .resp_pos(resp_pos), .resp_code(resp_code),
    .wr_resp_valid(wr_resp_valid), .rd_resp_valid(rd_resp_valid),
    .lcl_resp_tag(lcl_resp_tag), .lcl_resp_data(lcl_resp_data),
    .lcl_resp_pos(lcl_resp_pos), .lcl_resp_code(lcl_resp_code),
    .outst_wr(outst_wr), .outst_rd(outst_rd),
    .idle(idle), .fir_underflow(fir_underflow)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic drive_pl();
    wr_cmd_ea   = 64'h1000 + 64'(wr_n);
    wr_cmd_tag  = 7'(wr_n);
    wr_cmd_be   = {2{wr_cmd_ea}};
    wr_cmd_data = {16{wr_cmd_ea}};
    rd_cmd_ea   = 64'h2000 + 64'(rd_n);
    rd_cmd_tag  = 7'(rd_n);
    rd_cmd_be   = {2{rd_cmd_ea}};
    rd_cmd_data = {16{rd_cmd_ea}};
  endtask

  task automatic step();
    logic wa, ra;
    #1;
    wa = wr_cmd_valid & wr_cmd_ready;
    ra = rd_cmd_valid & rd_cmd_ready;
    @(posedge clk);
    #1;
    if (wa) wr_n++;
    if (ra) rd_n++;
    drive_pl();
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    wr_cmd_valid = 1'b0;
    rd_cmd_valid = 1'b0;
    m_cmd_ready  = 1'b1;
    auto_rsp     = 1'b0;
    man_valid    = 1'b0;
    man_tag      = '0;
    man_pos      = '0;
    resp_data    = '0;
    resp_code    = '0;
    wr_n         = 0;
    rd_n         = 0;
    drive_pl();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [11:0] pat;
    int cnt;

    do_reset();
    chk("rst_mvalid", 64'(m_cmd_valid), 64'd0);
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_outst", 64'({outst_wr, outst_rd}), 64'd0);
    chk("rst_fir", 64'(fir_underflow), 64'd0);

    // Weighted round robin with both channels busy.
    do_reset();
    auto_rsp     = 1'b1;
    wr_cmd_valid = 1'b1;
    rd_cmd_valid = 1'b1;
    pat = 12'b0000_1111_0000;
    for (int i = 0; i < 12; i++) begin
      step();
      chk($sformatf("t1_g%0d", i),
          64'({m_cmd_valid, m_cmd_rd, m_cmd_tag[7]}),
          64'({1'b1, pat[11-i], pat[11-i]}));
    end
    chk("t1_last_ea", m_cmd_ea, 64'h1007);
    chk("t1_counts", 64'(wr_n * 16 + rd_n), 64'(8 * 16 + 4));

    // Lone reader streams without weight throttling.
    do_reset();
    auto_rsp     = 1'b1;
    rd_cmd_valid = 1'b1;
    cnt = 0;
    #1;
    chk("t2_ready", 64'(rd_cmd_ready), 64'd1);
    for (int i = 0; i < 10; i++) begin
      step();
      if (m_cmd_valid && m_cmd_rd) cnt++;
    end
    rd_cmd_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      if (m_cmd_valid && m_cmd_rd) cnt++;
    end
    chk("t2_grants", 64'(cnt), 64'd10);
    chk("t2_accepts", 64'(rd_n), 64'd10);

    // Outstanding limit on the write channel.
    do_reset();
    wr_cmd_valid = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("t3_outst4", 64'(outst_wr), 64'd4);
    chk("t3_accepts", 64'(wr_n), 64'd4);
    #1;
    chk("t3_ready0", 64'(wr_cmd_ready), 64'd0);
    man_valid = 1'b1;
    man_tag   = 8'h03;
    man_pos   = 2'b10;
    step();
    man_valid = 1'b0;
    chk("t3_outst3", 64'(outst_wr), 64'd3);
    chk("t3_wr_resp", 64'({wr_resp_valid, rd_resp_valid}), 64'b10);
    chk("t3_lcl_tag", 64'(lcl_resp_tag), 64'h03);
    #1;
    chk("t3_ready1", 64'(wr_cmd_ready), 64'd1);
    step();
    wr_cmd_valid = 1'b0;
    chk("t3_outst4b", 64'(outst_wr), 64'd4);
    chk("t3_tag5th", 64'(m_cmd_tag), 64'h04);

    // Output backpressure holds the registered command.
    do_reset();
    m_cmd_ready  = 1'b0;
    wr_cmd_valid = 1'b1;
    rd_cmd_valid = 1'b1;
    step();
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("t4_rdy%0d", i),
          64'({wr_cmd_ready, rd_cmd_ready}), 64'd0);
      chk($sformatf("t4_hold%0d", i),
          m_cmd_ea ^ 64'({m_cmd_valid, m_cmd_tag}), 64'h1000 ^ 64'h100);
    end
    m_cmd_ready = 1'b1;
    step();
    wr_cmd_valid = 1'b0;
    rd_cmd_valid = 1'b0;
    chk("t4_next_ea", m_cmd_ea, 64'h1001);
    chk("t4_data", m_cmd_data[1023:960], 64'h1001);
    chk("t4_counts", 64'(wr_n * 16 + rd_n), 64'(2 * 16));

    // Response routing and final-part decrement.
    do_reset();
    rd_cmd_valid = 1'b1;
    step();
    rd_cmd_valid = 1'b0;
    chk("t5_outst1", 64'(outst_rd), 64'd1);
    chk("t5_busy", 64'(idle), 64'd0);
    man_valid = 1'b1;
    man_tag   = 8'h85;
    man_pos   = 2'b11;
    resp_code = 3'd5;
    resp_data = {16{64'hABCD_0123_4567_89EF}};
    step();
    man_valid = 1'b0;
    chk("t5_route", 64'({wr_resp_valid, rd_resp_valid}), 64'b01);
    chk("t5_tag", 64'(lcl_resp_tag), 64'h05);
    chk("t5_code_pos", 64'({lcl_resp_code, lcl_resp_pos}), 64'({3'd5, 2'b11}));
    chk("t5_data", lcl_resp_data[63:0], 64'hABCD_0123_4567_89EF);
    chk("t5_outst0", 64'(outst_rd), 64'd0);
    chk("t5_idle", 64'(idle), 64'd1);
    man_valid = 1'b1;
    man_pos   = 2'b01;
    step();
    man_valid = 1'b0;
    chk("t5_route_p01", 64'(rd_resp_valid), 64'd1);
    chk("t5_p01_cnt", 64'({outst_rd, fir_underflow}), 64'd0);
    step();
    chk("t5_strobe_drop", 64'(rd_resp_valid), 64'd0);

    // Simultaneous increment/decrement, then reset mid-stream.
    do_reset();
    rd_cmd_valid = 1'b1;
    step();
    man_valid = 1'b1;
    man_tag   = 8'h80;
    man_pos   = 2'b10;
    step();
    man_valid    = 1'b0;
    rd_cmd_valid = 1'b0;
    chk("t6_inc_dec", 64'(outst_rd), 64'd1);
    chk("t6_no_fir", 64'(fir_underflow), 64'd0);
    wr_cmd_valid = 1'b1;
    rd_cmd_valid = 1'b1;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_mvalid", 64'(m_cmd_valid), 64'd0);
    chk("t6_rst_outst", 64'({outst_wr, outst_rd}), 64'd0);
    chk("t6_rst_idle", 64'(idle), 64'd1);
    wr_cmd_valid = 1'b0;
    rd_cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    man_valid = 1'b1;
    man_tag   = 8'h80;
    man_pos   = 2'b10;
    step();
    man_valid = 1'b0;
    chk("t6_late_route", 64'(rd_resp_valid), 64'd1);
    chk("t6_fir", 64'(fir_underflow), 64'd1);
    chk("t6_outst_hold0", 64'(outst_rd), 64'd0);
    step();
    chk("t6_fir_sticky", 64'(fir_underflow), 64'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
